// File: rtl/spi_sram_slave.sv
// spi_sram_slave: SPI mode-0 serial SRAM device, oversampled by clk.
// All SPI pins are synchronised into clk. Edges of the synced sck drive a
// command/address/data FSM over a DEPTH-byte memory. A status register
// selects byte, page or sequential mode and can disable hold.
// Ports:
//   clk, rst           system clock (>= 4x sck), synchronous active-high reset
//   cs_n, sck, si      SPI inputs (asynchronous to clk)
//   hold_n             hold, active low
//   so, so_oe          serial data out and its tri-state enable
//   busy               synced chip select is active
//   err_cmd            one-clk pulse when an undecoded opcode is received
module spi_sram_slave #(
   parameter int ADDR_W      = 15,
   parameter int ADDR_BYTES  = 2,
   parameter int PAGE_W      = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic cs_n,
   input  logic sck,
   input  logic si,
   input  logic hold_n,
   output logic so,
   output logic so_oe,
   output logic busy,
   output logic err_cmd
);
   localparam int DEPTH = 2**ADDR_W;
   localparam int SHW   = (ADDR_W > 8) ? ADDR_W : 8;
   localparam int CW    = $clog2(8*ADDR_BYTES);
   localparam logic [CW-1:0] BYTE_LAST = CW'(7);
   localparam logic [CW-1:0] ADDR_LAST = CW'(8*ADDR_BYTES-1);

   typedef enum logic [2:0] {CMD, ADDR, RD_DATA, WR_DATA, RD_SR, WR_SR, FAULT} state_t;

   logic [SYNC_STAGES-1:0] sck_sr, cs_sr, si_sr, hold_sr;
   logic sck_s, cs_s, si_s, hold_s, sck_d;
   logic rise, fall, held, rise_a, fall_a;

   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [SHW-2:0] shf_i;
   logic [SHW-1:0] sh_next;
   logic [7:0] shf_o;
   logic [ADDR_W-1:0] addr, addr_nxt;
   logic [1:0] mode;
   logic hold_dis, is_rd, is_rd_n, load_q, oe_q;
   logic err, addr_ld, addr_inc, mem_we, ld_rd, ld_sr, sr_we, rd_state, byte_md;

   logic [7:0] mem [DEPTH];

   // cs_n and hold_n synchronisers reset to their inactive (high) level.
   always_ff @(posedge clk) begin
      if (rst) begin
         sck_sr  <= '0;
         cs_sr   <= '1;
         si_sr   <= '0;
         hold_sr <= '1;
         sck_d   <= 1'b0;
      end else begin
         sck_sr  <= {sck_sr[SYNC_STAGES-2:0], sck};
         cs_sr   <= {cs_sr[SYNC_STAGES-2:0], cs_n};
         si_sr   <= {si_sr[SYNC_STAGES-2:0], si};
         hold_sr <= {hold_sr[SYNC_STAGES-2:0], hold_n};
         sck_d   <= sck_s;
      end
   end

   assign sck_s  = sck_sr[SYNC_STAGES-1];
   assign cs_s   = cs_sr[SYNC_STAGES-1];
   assign si_s   = si_sr[SYNC_STAGES-1];
   assign hold_s = hold_sr[SYNC_STAGES-1];

   assign rise   = sck_s & ~sck_d;
   assign fall   = ~sck_s & sck_d;
   assign held   = ~hold_s & ~hold_dis;
   assign rise_a = rise & ~cs_s & ~held;
   assign fall_a = fall & ~cs_s & ~held;

   // Only the low SHW bits of the address field survive the shift; higher
   // address bits fall off the top, which is how they are ignored.
   assign sh_next  = {shf_i, si_s};
   assign rd_state = (state == RD_DATA) || (state == RD_SR);
   assign byte_md  = (mode[1] == mode[0]);   // 00 and 11 both act as byte mode

   assign busy  = ~cs_s;
   assign so_oe = oe_q & ~held;

   always_comb begin
      addr_nxt = addr + 1'b1;
      if (mode == 2'b10) begin
         addr_nxt = addr;
         addr_nxt[PAGE_W-1:0] = addr[PAGE_W-1:0] + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CMD;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      is_rd_n  = is_rd;
      err      = 1'b0;
      addr_ld  = 1'b0;
      addr_inc = 1'b0;
      mem_we   = 1'b0;
      ld_rd    = 1'b0;
      ld_sr    = 1'b0;
      sr_we    = 1'b0;
      if (cs_s) begin
         state_n = CMD;
         cnt_n   = '0;
      end else if (rise_a && state != FAULT) begin
         cnt_n = cnt + 1'b1;
         case (state)
            CMD: if (cnt == BYTE_LAST) begin
               cnt_n = '0;
               case (sh_next[7:0])
                  8'h03:   begin state_n = ADDR;  is_rd_n = 1'b1; end
                  8'h02:   begin state_n = ADDR;  is_rd_n = 1'b0; end
                  8'h05:   begin state_n = RD_SR; ld_sr = 1'b1;   end
                  8'h01:   state_n = WR_SR;
                  default: begin state_n = FAULT; err = 1'b1;     end
               endcase
            end
            ADDR: if (cnt == ADDR_LAST) begin
               cnt_n   = '0;
               addr_ld = 1'b1;
               state_n = is_rd ? RD_DATA : WR_DATA;
               ld_rd   = is_rd;   // prefetch the first byte before the next fall
            end
            RD_DATA: if (cnt == BYTE_LAST) begin
               cnt_n = '0;
               if (byte_md) state_n = FAULT;
               else begin
                  addr_inc = 1'b1;
                  ld_rd    = 1'b1;
               end
            end
            WR_DATA: if (cnt == BYTE_LAST) begin
               cnt_n    = '0;
               mem_we   = 1'b1;
               addr_inc = 1'b1;
               if (byte_md) state_n = FAULT;
            end
            RD_SR: if (cnt == BYTE_LAST) state_n = FAULT;
            WR_SR: if (cnt == BYTE_LAST) begin
               sr_we   = 1'b1;
               state_n = FAULT;
            end
            default: state_n = FAULT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shf_i    <= '0;
         shf_o    <= '0;
         addr     <= '0;
         mode     <= 2'b00;
         hold_dis <= 1'b0;
         is_rd    <= 1'b0;
         load_q   <= 1'b0;
         oe_q     <= 1'b0;
         so       <= 1'b0;
         err_cmd  <= 1'b0;
      end else begin
         err_cmd <= err;
         is_rd   <= is_rd_n;
         load_q  <= ld_rd;
         if (rise_a) shf_i <= sh_next[SHW-2:0];
         if (addr_ld) addr <= sh_next[ADDR_W-1:0];
         else if (addr_inc) addr <= addr_nxt;
         if (sr_we) begin
            mode     <= sh_next[7:6];
            hold_dis <= sh_next[0];
         end
         // Output enable follows the state on falls, so it drops on the
         // first fall after a read has finished.
         if (cs_s) oe_q <= 1'b0;
         else if (fall_a) oe_q <= rd_state;
         // load_q is one clk after the rise, so addr already holds the new
         // address; a fall is always at least two clks after a rise.
         if (ld_sr) shf_o <= {mode, 5'b0, hold_dis};
         else if (load_q) shf_o <= mem[addr];
         else if (fall_a && rd_state) begin
            so    <= shf_o[7];
            shf_o <= {shf_o[6:0], 1'b0};
         end
      end
   end

   // No reset on the array: contents survive rst; a write needs the full
   // eighth bit outside reset.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) mem[addr] <= sh_next[7:0];
   end
endmodule

// File: tb/tb_spi_sram_slave.sv
// tb_spi_sram_slave: randomized and directed bench for spi_sram_slave.
// A memory/status model predicts every byte the device shifts out; the
// expectations are queued and a monitor on sck checks them as they appear.
module tb_spi_sram_slave;
   localparam int HALF  = 80;
   localparam int DEPTH = 32768;

   logic clk = 1'b0, rst = 1'b1, cs_n = 1'b1, sck = 1'b0, si = 1'b0, hold_n = 1'b1;
   logic so, so_oe, busy, err_cmd;

   spi_sram_slave dut (
      .clk(clk), .rst(rst), .cs_n(cs_n), .sck(sck), .si(si), .hold_n(hold_n),
      .so(so), .so_oe(so_oe), .busy(busy), .err_cmd(err_cmd)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0, err_cnt = 0;
   logic [7:0] mdl [DEPTH];
   logic [1:0] m_mode = 2'b00;
   logic       m_hd = 1'b0;
   logic [7:0] exp_q [$];

   task automatic check(input string nm, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp_v, $time);
      end
   endtask

   always @(posedge clk) if (err_cmd) err_cnt++;

   // Monitor: assemble bytes on master sampling edges while the device drives.
   logic [7:0] mon_sh = 8'h00;
   int mon_n = 0;
   always @(posedge sck or posedge cs_n) begin
      if (cs_n) mon_n = 0;
      else if (so_oe) begin
         mon_sh = {mon_sh[6:0], so};
         mon_n++;
         if (mon_n == 8) begin
            mon_n = 0;
            if (exp_q.size() == 0) check("unexpected_read_byte", 0, 1);
            else check("read_byte", int'(mon_sh), int'(exp_q.pop_front()));
         end
      end
   end

   function automatic bit byte_mode();
      return m_mode == 2'b00 || m_mode == 2'b11;
   endfunction

   function automatic int adv(input int a);
      if (m_mode == 2'b10) return (a & ~31) | ((a + 1) & 31);
      return (a + 1) % DEPTH;
   endfunction

   task automatic xbit(input logic b, output logic oe);
      si = b;
      #HALF sck = 1'b1;
      oe = so_oe;
      #HALF sck = 1'b0;
   endtask

   task automatic xfer(input logic [7:0] tx, output logic oe);
      logic o;
      oe = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         xbit(tx[i], o);
         oe |= o;
      end
   endtask

   task automatic start();
      cs_n = 1'b0;
      #HALF;
   endtask

   task automatic stop();
      #HALF cs_n = 1'b1;
      #(2*HALF);
      check("exp_q_drained", exp_q.size(), 0);
   endtask

   task automatic wrsr(input logic [7:0] v);
      logic o;
      start(); xfer(8'h01, o); xfer(v, o); stop();
      m_mode = v[7:6];
      m_hd   = v[0];
   endtask

   task automatic rdsr();
      logic o;
      start(); xfer(8'h05, o);
      exp_q.push_back({m_mode, 5'b0, m_hd});
      xfer(8'h00, o); stop();
   endtask

   task automatic send_addr(input logic [7:0] op, input int a);
      logic o;
      xfer(op, o); xfer(8'(a >> 8), o); xfer(8'(a), o);
   endtask

   task automatic sram_write(input int a, input logic [7:0] d [4], input int n);
      logic o;
      int ad = a;
      start(); send_addr(8'h02, a);
      for (int i = 0; i < n; i++) begin
         if (i == 0 || !byte_mode()) begin
            mdl[ad] = d[i];
            ad = adv(ad);
         end
         xfer(d[i], o);
      end
      stop();
   endtask

   task automatic sram_read(input int a, input int n, output logic oe_tail);
      logic o;
      int ad = a;
      oe_tail = 1'b0;
      start(); send_addr(8'h03, a);
      for (int i = 0; i < n; i++) begin
         if (i == 0 || !byte_mode()) begin
            exp_q.push_back(mdl[ad]);
            ad = adv(ad);
         end
         xfer(8'h00, o);
         if (i > 0) oe_tail |= o;
      end
      stop();
   endtask

   initial begin
      logic o, tail;
      int e0, a, n;
      logic [7:0] d [4];

      repeat (5) @(negedge clk);
      check("rst_so_oe", so_oe, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err_cmd, 0);
      check("rst_so", so, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      cs_n = 1'b0;
      #HALF check("busy_active", busy, 1);
      cs_n = 1'b1;
      #(2*HALF);

      // Byte mode write then read; the second read byte must not be driven.
      wrsr(8'h00);
      sram_write(16'h0010, '{8'hA5, 8'h00, 8'h00, 8'h00}, 1);
      sram_read(16'h0010, 2, tail);
      check("byte_mode_tail_oe", tail, 0);

      // Sequential mode wraps from the top of memory to 0.
      wrsr(8'h40);
      sram_write(16'h7FFF, '{8'h11, 8'h22, 8'h00, 8'h00}, 2);
      sram_read(16'h7FFF, 2, tail);
      sram_read(16'h0000, 1, tail);

      // Page mode wraps within the 32-byte page; 0x20 must stay untouched.
      sram_write(16'h0020, '{8'h77, 8'h00, 8'h00, 8'h00}, 1);
      wrsr(8'h80);
      sram_write(16'h001F, '{8'h01, 8'h02, 8'h00, 8'h00}, 2);
      sram_read(16'h001F, 2, tail);
      sram_read(16'h0020, 1, tail);

      // Undecoded opcode: one err pulse, nothing driven, status intact.
      wrsr(8'h41);
      e0 = err_cnt;
      start(); xfer(8'h0A, o); xfer(8'h00, tail); o |= tail; stop();
      check("err_cmd_pulses", err_cnt - e0, 1);
      check("bad_op_so_oe", o, 0);
      rdsr();

      // Hold mid-read: output released, no bits lost after resuming.
      wrsr(8'h00);
      sram_write(16'h0100, '{8'hC3, 8'h00, 8'h00, 8'h00}, 1);
      start(); send_addr(8'h03, 16'h0100);
      exp_q.push_back(mdl[16'h0100]);
      for (int i = 0; i < 4; i++) xbit(1'b0, o);
      #(HALF/2) hold_n = 1'b0;
      #(HALF/2) check("held_so_oe", so_oe, 0);
      repeat (4) begin
         #HALF sck = 1'b1;
         #HALF sck = 1'b0;
      end
      #(HALF/2) hold_n = 1'b1;
      for (int i = 0; i < 4; i++) xbit(1'b0, o);
      check("resumed_so_oe", o, 1);
      stop();

      // With hold disabled, hold_n low throughout has no effect.
      wrsr(8'h01);
      hold_n = 1'b0;
      sram_read(16'h0100, 1, tail);
      rdsr();
      hold_n = 1'b1;

      // Write aborted by cs_n after 5 data bits.
      wrsr(8'h00);
      sram_write(16'h0040, '{8'h5A, 8'h00, 8'h00, 8'h00}, 1);
      start(); send_addr(8'h02, 16'h0040);
      for (int i = 0; i < 5; i++) xbit(1'b1, o);
      stop();
      sram_read(16'h0040, 1, tail);

      // Write aborted by rst spanning the final data bits.
      wrsr(8'h41);
      start(); send_addr(8'h02, 16'h0040);
      for (int i = 0; i < 5; i++) xbit(1'b1, o);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) xbit(1'b1, o);
      cs_n = 1'b1;
      #HALF;
      check("rst_mid_so_oe", so_oe, 0);
      check("rst_mid_busy", busy, 0);
      rst = 1'b0;
      m_mode = 2'b00;
      m_hd   = 1'b0;
      #(2*HALF);
      rdsr();
      sram_read(16'h0040, 1, tail);

      // Randomized write/read-back across modes.
      for (int k = 0; k < 12; k++) begin
         case ($urandom_range(0, 2))
            0: wrsr(8'h00);
            1: wrsr(8'h40);
            default: wrsr(8'h80);
         endcase
         a = $urandom_range(0, DEPTH - 1);
         n = $urandom_range(1, 4);
         for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
         sram_write(a, d, n);
         sram_read(a, n, tail);
         if (byte_mode() && n > 1) check("rand_byte_tail_oe", tail, 0);
      end

      check("final_exp_q", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
